// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate vector sequencer and its golden model.
package gate_seq_pkg;

    localparam int Y_W   = 6;
    localparam int VEC_N = 4;
    localparam int VEC_W = 2;
    localparam int CNT_W = 4;
    localparam int ERR_W = 3;

    // Bit positions inside the gate output word y
    localparam int IDX_AND  = 5;
    localparam int IDX_NAND = 4;
    localparam int IDX_NOR  = 3;
    localparam int IDX_OR   = 2;
    localparam int IDX_XNOR = 1;
    localparam int IDX_XOR  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/gate_expected.sv
// Combinational golden model: expected gate outputs for a 2-bit input vector {a,b}.
module gate_expected
    import gate_seq_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [Y_W-1:0]   expected
);

    logic in_a;
    logic in_b;

    assign in_a = vec[1];
    assign in_b = vec[0];

    always_comb begin
        expected           = '0;
        expected[IDX_AND]  = in_a & in_b;
        expected[IDX_NAND] = ~(in_a & in_b);
        expected[IDX_NOR]  = ~(in_a | in_b);
        expected[IDX_OR]   = in_a | in_b;
        expected[IDX_XNOR] = ~(in_a ^ in_b);
        expected[IDX_XOR]  = in_a ^ in_b;
    end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Steps a 2-input gate block through all four input vectors, checks its outputs
// against the golden model and accumulates pass/fail status.
module gate_vector_sequencer
    import gate_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Y_W-1:0]   y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_N-1:0] err_mask,
    output logic [Y_W-1:0]   fail_bits
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(VEC_N - 1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [VEC_W-1:0]  idx;
    logic [CNT_W-1:0]  settle_cnt;
    logic [Y_W-1:0]    expected;
    logic [Y_W-1:0]    diff;
    logic              mismatch;
    logic [ERR_W-1:0]  err_count_next;
    logic [VEC_N-1:0]  idx_onehot;
    logic              last_vec;

    gate_expected u_expected (
        .vec      (idx),
        .expected (expected)
    );

    assign diff           = y ^ expected;
    assign mismatch       = |diff;
    assign err_count_next = mismatch ? err_count + ERR_W'(1) : err_count;
    assign idx_onehot     = VEC_N'(1) << idx;
    assign last_vec       = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE,
            ST_DONE:   if (start) next_state = ST_DRIVE;
            ST_DRIVE:  next_state = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == '0) next_state = ST_CHECK;
            ST_CHECK:  next_state = last_vec ? ST_DONE : ST_DRIVE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Datapath: stimulus, settle timer and result registers all move in lockstep with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            settle_cnt <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            err_mask   <= '0;
            fail_bits  <= '0;
        end else begin
            case (state)
                ST_IDLE,
                ST_DONE: begin
                    if (start) begin
                        idx       <= '0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        err_mask  <= '0;
                        fail_bits <= '0;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    err_count <= err_count_next;
                    if (mismatch) begin
                        err_mask  <= err_mask | idx_onehot;
                        fail_bits <= fail_bits | diff;
                    end
                    if (last_vec) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count_next == '0);
                    end else begin
                        idx <= idx + VEC_W'(1);
                        a   <= (idx + VEC_W'(1)) >> 1;
                        b   <= idx[0] ^ 1'b1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    pass <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed self-checking bench: a behavioural gate block with injectable faults drives two sequencers (S=1, S=3).
module tb_gate_vector_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start1;
    logic       start3;
    logic [5:0] y1;
    logic [5:0] y3;
    logic       a1, b1, busy1, done1, pass1;
    logic       a3, b3, busy3, done3, pass3;
    logic [2:0] err_count1, err_count3;
    logic [3:0] err_mask1, err_mask3;
    logic [5:0] fail_bits1, fail_bits3;

    int checkCount;
    int failCount;
    int cyc;
    int faultMode;

    gate_vector_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .err_mask(err_mask1), .fail_bits(fail_bits1)
    );

    gate_vector_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .y(y3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err_count3), .err_mask(err_mask3), .fail_bits(fail_bits3)
    );

    function automatic logic [5:0] gateBlock(input logic ga, input logic gb, input int mode);
        logic [5:0] r;
        r = {ga & gb, ~(ga & gb), ~(ga | gb), ga | gb, ~(ga ^ gb), ga ^ gb};
        if (mode == 1) r[0] = 1'b0;
        if (mode == 2) r = 6'b111111;
        return r;
    endfunction

    assign y1 = gateBlock(a1, b1, faultMode);
    assign y3 = gateBlock(a3, b3, faultMode);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkResults(input int sel, input logic expPass, input logic [2:0] expCnt,
                                input logic [3:0] expMask, input logic [5:0] expFail);
        if (sel == 3) begin
            checkOutput("s3 pass", 32'(pass3), 32'(expPass));
            checkOutput("s3 err_count", 32'(err_count3), 32'(expCnt));
            checkOutput("s3 err_mask", 32'(err_mask3), 32'(expMask));
            checkOutput("s3 fail_bits", 32'(fail_bits3), 32'(expFail));
        end else begin
            checkOutput("s1 pass", 32'(pass1), 32'(expPass));
            checkOutput("s1 err_count", 32'(err_count1), 32'(expCnt));
            checkOutput("s1 err_mask", 32'(err_mask1), 32'(expMask));
            checkOutput("s1 fail_bits", 32'(fail_bits1), 32'(expFail));
        end
    endtask

    // Pulses start, then walks every cycle of the run checking the vector, busy, done and pass.
    task automatic applyStimulus(input int sel, input int s, input bit injectStart);
        int hold;
        logic [1:0] ab;
        logic bz, dn, ps;
        logic [2:0] ec;
        logic [3:0] em;
        logic [5:0] fb;
        hold = s + 2;
        @(negedge clk);
        if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        for (int k = 0; k <= 4 * hold; k++) begin
            ab = (sel == 3) ? {a3, b3} : {a1, b1};
            bz = (sel == 3) ? busy3 : busy1;
            dn = (sel == 3) ? done3 : done1;
            ps = (sel == 3) ? pass3 : pass1;
            ec = (sel == 3) ? err_count3 : err_count1;
            em = (sel == 3) ? err_mask3 : err_mask1;
            fb = (sel == 3) ? fail_bits3 : fail_bits1;
            if (k == 0) begin
                checkOutput("cleared err_count", 32'(ec), 32'd0);
                checkOutput("cleared err_mask", 32'(em), 32'd0);
                checkOutput("cleared fail_bits", 32'(fb), 32'd0);
            end
            if (k < 4 * hold) begin
                checkOutput("vector ab", 32'(ab), 32'(k / hold));
                checkOutput("busy in run", 32'(bz), 32'd1);
                checkOutput("done in run", 32'(dn), 32'd0);
                checkOutput("pass in run", 32'(ps), 32'd0);
            end else begin
                checkOutput("done at end", 32'(dn), 32'd1);
                checkOutput("busy at end", 32'(bz), 32'd0);
                checkOutput("ab held", 32'(ab), 32'd3);
            end
            if (injectStart && k == 6) begin
                if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
            end else begin
                start1 = 1'b0;
                start3 = 1'b0;
            end
            if (k < 4 * hold) @(negedge clk);
        end
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        cyc        = 0;
        faultMode  = 0;
        start1     = 1'b0;
        start3     = 1'b0;
        rst_n      = 1'b0;
        #1;
        checkOutput("reset a", 32'(a1), 32'd0);
        checkOutput("reset b", 32'(b1), 32'd0);
        checkOutput("reset busy", 32'(busy1), 32'd0);
        checkOutput("reset done", 32'(done1), 32'd0);
        checkResults(1, 1'b0, 3'd0, 4'b0000, 6'b000000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle no start", 32'(busy1), 32'd0);

        $display("[TB] correct gate block, S=1");
        applyStimulus(1, 1, 1'b0);
        checkResults(1, 1'b1, 3'd0, 4'b0000, 6'b000000);

        $display("[TB] xor stuck at 0");
        faultMode = 1;
        applyStimulus(1, 1, 1'b0);
        checkResults(1, 1'b0, 3'd2, 4'b0110, 6'b000001);

        $display("[TB] y stuck at all ones");
        faultMode = 2;
        applyStimulus(1, 1, 1'b0);
        checkResults(1, 1'b0, 3'd4, 4'b1111, 6'b111111);

        $display("[TB] restart from failing DONE with correct block");
        faultMode = 0;
        applyStimulus(1, 1, 1'b0);
        checkResults(1, 1'b1, 3'd0, 4'b0000, 6'b000000);

        $display("[TB] S=3 with start during busy");
        applyStimulus(3, 3, 1'b1);
        checkResults(3, 1'b1, 3'd0, 4'b0000, 6'b000000);

        $display("[TB] reset during vector 2");
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("mid-run vector", 32'({a1, b1}), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset a", 32'(a1), 32'd0);
        checkOutput("async reset b", 32'(b1), 32'd0);
        checkOutput("async reset busy", 32'(busy1), 32'd0);
        checkOutput("async reset done", 32'(done1), 32'd0);
        checkResults(1, 1'b0, 3'd0, 4'b0000, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle after reset", 32'(busy1), 32'd0);
        applyStimulus(1, 1, 1'b0);
        checkResults(1, 1'b1, 3'd0, 4'b0000, 6'b000000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
